// File: rtl/hazard_ctrl_pkg.sv
// Shared types, encodings and helpers for the pipeline hazard controller.
// Holds the forwarding-select encoding and the mult/div default latencies.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_E  = 2'd1,
    FWD_M  = 2'd2,
    FWD_W  = 2'd3
  } fwd_sel_e;

  localparam logic [1:0] TUSE_NONE       = 2'd3;
  localparam int         MULT_CYCLES_DEF = 5;
  localparam int         DIV_CYCLES_DEF  = 10;

  // Register 0 is hardwired, so it never names a real producer or consumer.
  function automatic logic reg_hit(logic [4:0] src, logic [4:0] dst);
    return (src != 5'd0) && (src == dst);
  endfunction

  // A consumer must wait if the producer's result arrives after it is needed.
  function automatic logic too_late(logic [4:0] src, logic [1:0] tuse,
                                    logic [4:0] dst, logic [1:0] tnew);
    return (tuse != TUSE_NONE) && reg_hit(src, dst) && (tnew > tuse);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller (slave).
// Carries decoded register usage per stage and the returned stall/forward controls.
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  logic [4:0] rs_d;
  logic [4:0] rt_d;
  logic [1:0] tuse_rs_d;
  logic [1:0] tuse_rt_d;
  logic [4:0] rs_e;
  logic [4:0] rt_e;
  logic [4:0] wa_e;
  logic [1:0] tnew_e;
  logic [4:0] wa_m;
  logic [1:0] tnew_m;
  logic [4:0] wa_w;
  logic       md_use_d;
  logic       md_start_e;
  logic       md_div_e;

  logic       stall_d;
  logic       flush_e;
  fwd_sel_e   fwd_rs_d;
  fwd_sel_e   fwd_rt_d;
  fwd_sel_e   fwd_rs_e;
  fwd_sel_e   fwd_rt_e;
  logic       md_busy;

  modport master (
    output rs_d, rt_d, tuse_rs_d, tuse_rt_d, rs_e, rt_e,
           wa_e, tnew_e, wa_m, tnew_m, wa_w,
           md_use_d, md_start_e, md_div_e,
    input  stall_d, flush_e, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, md_busy
  );

  modport slave (
    input  rs_d, rt_d, tuse_rs_d, tuse_rt_d, rs_e, rt_e,
           wa_e, tnew_e, wa_m, tnew_m, wa_w,
           md_use_d, md_start_e, md_div_e,
    output stall_d, flush_e, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, md_busy
  );

endinterface

// File: rtl/hazard_ctrl_md_busy_cnt.sv
// Busy-cycle counter of the multi-cycle mult/div unit.
// A start (re)loads the operation latency; otherwise it counts down to zero.
module md_busy_cnt
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic clr,
  input  logic start_i,
  input  logic div_i,
  output logic busy_o
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // NOTE: cnt_d takes its hold value first so every path assigns it and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = div_i ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  // NOTE: state updates use <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (!clr) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != 4'd0);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush and forwarding-select generation for the 5-stage pipeline.
// Combinational on the stage inputs plus the registered mult/div busy state.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic          clk,
  input  logic          clr,
  hazard_ctrl_if.slave  bus
);

  logic md_busy;
  logic data_stall;
  logic md_stall;
  logic stall;

  md_busy_cnt #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy_cnt (
    .clk     (clk),
    .clr     (clr),
    .start_i (bus.md_start_e),
    .div_i   (bus.md_div_e),
    .busy_o  (md_busy)
  );

  // D needs a result: E beats M beats W, and only results already available count.
  function automatic fwd_sel_e fwd_from_d(logic [4:0] s,
                                          logic [4:0] wa_e, logic [1:0] tnew_e,
                                          logic [4:0] wa_m, logic [1:0] tnew_m,
                                          logic [4:0] wa_w);
    if (reg_hit(s, wa_e) && (tnew_e == 2'd0))      return FWD_E;
    else if (reg_hit(s, wa_m) && (tnew_m == 2'd0)) return FWD_M;
    else if (reg_hit(s, wa_w))                     return FWD_W;
    else                                           return FWD_RF;
  endfunction

  function automatic fwd_sel_e fwd_from_e(logic [4:0] s,
                                          logic [4:0] wa_m, logic [1:0] tnew_m,
                                          logic [4:0] wa_w);
    if (reg_hit(s, wa_m) && (tnew_m == 2'd0)) return FWD_M;
    else if (reg_hit(s, wa_w))                return FWD_W;
    else                                      return FWD_RF;
  endfunction

  always_comb begin
    data_stall = too_late(bus.rs_d, bus.tuse_rs_d, bus.wa_e, bus.tnew_e)
               | too_late(bus.rs_d, bus.tuse_rs_d, bus.wa_m, bus.tnew_m)
               | too_late(bus.rt_d, bus.tuse_rt_d, bus.wa_e, bus.tnew_e)
               | too_late(bus.rt_d, bus.tuse_rt_d, bus.wa_m, bus.tnew_m);
    md_stall   = bus.md_use_d && (md_busy || bus.md_start_e);
    stall      = data_stall || md_stall;
  end

  assign bus.stall_d  = stall;
  assign bus.flush_e  = stall;
  assign bus.md_busy  = md_busy;

  assign bus.fwd_rs_d = fwd_from_d(bus.rs_d, bus.wa_e, bus.tnew_e, bus.wa_m, bus.tnew_m, bus.wa_w);
  assign bus.fwd_rt_d = fwd_from_d(bus.rt_d, bus.wa_e, bus.tnew_e, bus.wa_m, bus.tnew_m, bus.wa_w);
  assign bus.fwd_rs_e = fwd_from_e(bus.rs_e, bus.wa_m, bus.tnew_m, bus.wa_w);
  assign bus.fwd_rt_e = fwd_from_e(bus.rt_e, bus.wa_m, bus.tnew_m, bus.wa_w);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed plus randomized bench for hazard_ctrl against a stage-table model.
// Mult/div busy is modelled as an absolute end cycle rather than a counter.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk;
  logic clr;
  hazard_ctrl_if bus ();

  hazard_ctrl #(
    .MULT_CYCLES (MULT_N),
    .DIV_CYCLES  (DIV_N)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int busy_end = 0;

  task automatic check(string tag, logic [3:0] obs, logic [3:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Producers listed in priority order E, M, W; W is always ready.
  function automatic logic [1:0] m_fwd(logic [4:0] s, bit from_e_stage);
    logic [4:0] wa [3];
    int         tn [3];
    wa[0] = bus.wa_e; tn[0] = int'(bus.tnew_e);
    wa[1] = bus.wa_m; tn[1] = int'(bus.tnew_m);
    wa[2] = bus.wa_w; tn[2] = 0;
    if (s == 5'd0) return 2'd0;
    for (int k = (from_e_stage ? 1 : 0); k < 3; k++)
      if (wa[k] == s && tn[k] == 0) return 2'(k + 1);
    return 2'd0;
  endfunction

  function automatic bit m_busy();
    return cyc < busy_end;
  endfunction

  function automatic bit m_stall();
    logic [4:0] src [2];
    int         tu  [2];
    logic [4:0] wa  [2];
    int         tn  [2];
    src[0] = bus.rs_d; tu[0] = int'(bus.tuse_rs_d);
    src[1] = bus.rt_d; tu[1] = int'(bus.tuse_rt_d);
    wa[0]  = bus.wa_e; tn[0] = int'(bus.tnew_e);
    wa[1]  = bus.wa_m; tn[1] = int'(bus.tnew_m);
    for (int i = 0; i < 2; i++)
      if (tu[i] != 3 && src[i] != 5'd0)
        for (int k = 0; k < 2; k++)
          if (wa[k] == src[i] && tn[k] > tu[i]) return 1'b1;
    return bus.md_use_d && (m_busy() || bus.md_start_e);
  endfunction

  // Check every output mid-cycle, then advance the model across the edge.
  task automatic cycle();
    @(negedge clk);
    check("stall_d",  {3'b0, bus.stall_d}, {3'b0, m_stall()});
    check("flush_e",  {3'b0, bus.flush_e}, {3'b0, m_stall()});
    check("md_busy",  {3'b0, bus.md_busy}, {3'b0, m_busy()});
    check("fwd_rs_d", {2'b0, bus.fwd_rs_d}, {2'b0, m_fwd(bus.rs_d, 1'b0)});
    check("fwd_rt_d", {2'b0, bus.fwd_rt_d}, {2'b0, m_fwd(bus.rt_d, 1'b0)});
    check("fwd_rs_e", {2'b0, bus.fwd_rs_e}, {2'b0, m_fwd(bus.rs_e, 1'b1)});
    check("fwd_rt_e", {2'b0, bus.fwd_rt_e}, {2'b0, m_fwd(bus.rt_e, 1'b1)});
    @(posedge clk);
    cyc++;
    if (!clr)                busy_end = cyc;
    else if (bus.md_start_e) busy_end = cyc + (bus.md_div_e ? DIV_N : MULT_N);
    #1;
  endtask

  task automatic zero_inputs();
    bus.rs_d = '0; bus.rt_d = '0; bus.tuse_rs_d = '0; bus.tuse_rt_d = '0;
    bus.rs_e = '0; bus.rt_e = '0; bus.wa_e = '0; bus.tnew_e = '0;
    bus.wa_m = '0; bus.tnew_m = '0; bus.wa_w = '0;
    bus.md_use_d = 1'b0; bus.md_start_e = 1'b0; bus.md_div_e = 1'b0;
  endtask

  task automatic expect_now(string tag, logic stall_exp, logic busy_exp);
    #1;
    check({tag, ".stall"}, {3'b0, bus.stall_d}, {3'b0, stall_exp});
    check({tag, ".busy"},  {3'b0, bus.md_busy}, {3'b0, busy_exp});
  endtask

  initial begin
    clr = 1'b0;
    zero_inputs();
    @(posedge clk);
    #1;
    expect_now("reset", 1'b0, 1'b0);
    check("reset.fwd_rs_d", {2'b0, bus.fwd_rs_d}, 4'd0);
    cycle();
    clr = 1'b1;
    cycle();

    // Load in E, consumer branch in D: stall until the value reaches M ready.
    bus.wa_e = 5'd8; bus.tnew_e = 2'd2; bus.rs_d = 5'd8; bus.tuse_rs_d = 2'd0;
    expect_now("lw_e", 1'b1, 1'b0);
    check("lw_e.flush", {3'b0, bus.flush_e}, 4'd1);
    cycle();
    bus.wa_e = 5'd0; bus.tnew_e = 2'd0; bus.wa_m = 5'd8; bus.tnew_m = 2'd1;
    expect_now("lw_m1", 1'b1, 1'b0);
    cycle();
    bus.tnew_m = 2'd0;
    expect_now("lw_m0", 1'b0, 1'b0);
    check("lw_m0.fwd_rs_d", {2'b0, bus.fwd_rs_d}, 4'd2);
    cycle();

    zero_inputs();
    bus.wa_e = 5'd9; bus.rt_d = 5'd9; bus.tuse_rt_d = 2'd1;
    expect_now("addu", 1'b0, 1'b0);
    check("addu.fwd_rt_d", {2'b0, bus.fwd_rt_d}, 4'd1);
    cycle();
    bus.wa_m = 5'd9;
    #1 check("e_beats_m", {2'b0, bus.fwd_rt_d}, 4'd1);
    cycle();

    zero_inputs();
    bus.tnew_e = 2'd2;
    expect_now("r0", 1'b0, 1'b0);
    check("r0.fwd_rs_d", {2'b0, bus.fwd_rs_d}, 4'd0);
    bus.rs_e = 5'd5; bus.wa_m = 5'd5;
    #1 check("e_fwd_m", {2'b0, bus.fwd_rs_e}, 4'd2);
    cycle();
    bus.wa_m = 5'd0; bus.wa_w = 5'd5;
    #1 check("e_fwd_w", {2'b0, bus.fwd_rs_e}, 4'd3);
    cycle();

    zero_inputs();
    bus.rs_d = 5'd7; bus.wa_e = 5'd7; bus.tnew_e = 2'd2; bus.tuse_rs_d = 2'd3;
    expect_now("tuse_none", 1'b0, 1'b0);
    cycle();
    bus.tuse_rs_d = 2'd2;
    expect_now("tuse_eq", 1'b0, 1'b0);
    cycle();
    bus.tuse_rs_d = 2'd1;
    expect_now("tuse_lt", 1'b1, 1'b0);
    cycle();

    // mult then div with an md-class instruction waiting in D throughout.
    for (int op = 0; op < 2; op++) begin
      int n;
      n = (op == 0) ? MULT_N : DIV_N;
      zero_inputs();
      bus.md_use_d = 1'b1; bus.md_start_e = 1'b1; bus.md_div_e = (op == 1);
      expect_now("md_start", 1'b1, 1'b0);
      cycle();
      bus.md_start_e = 1'b0;
      for (int i = 0; i < n; i++) begin
        expect_now("md_run", 1'b1, 1'b1);
        cycle();
      end
      expect_now("md_done", 1'b0, 1'b0);
      cycle();
    end

    zero_inputs();
    bus.md_use_d = 1'b1; bus.md_start_e = 1'b1; bus.md_div_e = 1'b1;
    cycle();
    bus.md_start_e = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    clr = 1'b0;
    expect_now("div_clr", 1'b1, 1'b1);
    cycle();
    clr = 1'b1;
    expect_now("after_clr", 1'b0, 1'b0);
    cycle();

    for (int i = 0; i < 400; i++) begin
      bus.rs_d = 5'($urandom_range(0, 3));  bus.rt_d = 5'($urandom_range(0, 3));
      bus.rs_e = 5'($urandom_range(0, 3));  bus.rt_e = 5'($urandom_range(0, 3));
      bus.wa_e = 5'($urandom_range(0, 3));  bus.wa_m = 5'($urandom_range(0, 3));
      bus.wa_w = 5'($urandom_range(0, 3));
      bus.tuse_rs_d = 2'($urandom_range(0, 3)); bus.tuse_rt_d = 2'($urandom_range(0, 3));
      bus.tnew_e = 2'($urandom_range(0, 2));    bus.tnew_m = 2'($urandom_range(0, 2));
      bus.md_use_d   = 1'($urandom_range(0, 1));
      bus.md_start_e = ($urandom_range(0, 9) == 0);
      bus.md_div_e   = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 39) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
